// File: rtl/lc3_ctrl_pkg.sv
// LC-3 control-store definitions: microinstruction field layout, COND codes,
// named micro-states and datapath control-word bit positions.
package lc3_ctrl_pkg;

   localparam int unsigned UWORD_W = 50;
   localparam int unsigned CTRL_W  = 40;
   localparam int unsigned IRD_BIT = 49;
   localparam int unsigned COND_HI = 48;
   localparam int unsigned COND_LO = 46;
   localparam int unsigned J_HI    = 45;
   localparam int unsigned J_LO    = 40;
   localparam int unsigned CTRL_HI = 39;
   localparam int unsigned CTRL_LO = 0;

   typedef enum logic [2:0] {
      C_NONE   = 3'd0,
      C_READY  = 3'd1,
      C_BRANCH = 3'd2,
      C_ADDR   = 3'd3,
      C_PSR    = 3'd4,
      C_INT    = 3'd5,
      C_ACV    = 3'd6,
      C_NONE7  = 3'd7
   } cond_e;

   typedef enum logic [5:0] {
      S_BR       = 6'd0,
      S_ADD      = 6'd1,
      S_AND      = 6'd5,
      S_NOT      = 6'd9,
      S_FETCH    = 6'd18,
      S_BR_TAKEN = 6'd22,
      S_DECODE   = 6'd32,
      S_MEMWAIT  = 6'd33,
      S_IRLD     = 6'd35,
      S_INT_VEC  = 6'd37,
      S_INT      = 6'd49,
      S_EXC      = 6'd60
   } state_e;

   // LSB position of each field inside the 40-bit datapath control word
   typedef enum int unsigned {
      LD_MAR      = 0,
      LD_MDR      = 1,
      LD_IR       = 2,
      LD_BEN      = 3,
      LD_REG      = 4,
      LD_CC       = 5,
      LD_PC       = 6,
      LD_PRIV     = 7,
      LD_SAVEDSSP = 8,
      LD_SAVEDUSP = 9,
      LD_VECTOR   = 10,
      GATE_PC     = 11,
      GATE_MDR    = 12,
      GATE_ALU    = 13,
      GATE_MARMUX = 14,
      GATE_VECTOR = 15,
      GATE_PC1    = 16,
      GATE_PSR    = 17,
      GATE_SP     = 18,
      PCMUX       = 19,
      DRMUX       = 21,
      SR1MUX      = 23,
      ADDR1MUX    = 25,
      ADDR2MUX    = 26,
      SPMUX       = 28,
      MARMUX      = 30,
      TABLEMUX    = 31,
      VECTORMUX   = 32,
      PSRMUX      = 34,
      ALUK        = 35,
      MIO_EN      = 37,
      R_W         = 38,
      SET_PRIV    = 39
   } ctrl_pos_e;

   function automatic logic [CTRL_W-1:0] cfld(input ctrl_pos_e pos, input logic [1:0] val);
      return CTRL_W'(val) << pos;
   endfunction

   function automatic logic [UWORD_W-1:0] uword(input logic ird, input cond_e cond,
                                                input state_e j, input logic [CTRL_W-1:0] ctrl);
      return {ird, cond, j, ctrl};
   endfunction

endpackage

// File: rtl/lc3_ctrl_store.sv
// 64x50 microcode ROM; unlisted addresses fall back to a side-effect-free
// word that returns to FETCH.
module lc3_ctrl_store
   import lc3_ctrl_pkg::*;
(
   input  logic [5:0]         addr_i,
   output logic [UWORD_W-1:0] word_o
);

   always_comb begin
      word_o = uword(1'b0, C_NONE, S_FETCH, '0);
      case (addr_i)
         S_FETCH:    word_o = uword(1'b0, C_INT, S_MEMWAIT,
                                    cfld(LD_MAR, 2'd1) | cfld(LD_PC, 2'd1) | cfld(GATE_PC, 2'd1));
         S_MEMWAIT:  word_o = uword(1'b0, C_READY, S_MEMWAIT, cfld(MIO_EN, 2'd1));
         S_IRLD:     word_o = uword(1'b0, C_NONE, S_DECODE,
                                    cfld(GATE_MDR, 2'd1) | cfld(LD_IR, 2'd1));
         S_DECODE:   word_o = uword(1'b1, C_NONE, S_FETCH, cfld(LD_BEN, 2'd1));
         S_ADD:      word_o = uword(1'b0, C_NONE, S_FETCH,
                                    cfld(LD_REG, 2'd1) | cfld(LD_CC, 2'd1) | cfld(GATE_ALU, 2'd1) |
                                    cfld(SR1MUX, 2'd1) | cfld(ALUK, 2'd0));
         S_AND:      word_o = uword(1'b0, C_NONE, S_FETCH,
                                    cfld(LD_REG, 2'd1) | cfld(LD_CC, 2'd1) | cfld(GATE_ALU, 2'd1) |
                                    cfld(SR1MUX, 2'd1) | cfld(ALUK, 2'd1));
         S_NOT:      word_o = uword(1'b0, C_NONE, S_FETCH,
                                    cfld(LD_REG, 2'd1) | cfld(LD_CC, 2'd1) | cfld(GATE_ALU, 2'd1) |
                                    cfld(SR1MUX, 2'd1) | cfld(ALUK, 2'd2));
         S_BR:       word_o = uword(1'b0, C_BRANCH, S_FETCH, '0);
         S_BR_TAKEN: word_o = uword(1'b0, C_NONE, S_FETCH,
                                    cfld(LD_PC, 2'd1) | cfld(PCMUX, 2'd2) | cfld(ADDR2MUX, 2'd2));
         S_INT:      word_o = uword(1'b0, C_NONE, S_INT_VEC,
                                    cfld(LD_MDR, 2'd1) | cfld(GATE_PSR, 2'd1) |
                                    cfld(LD_PRIV, 2'd1) | cfld(SET_PRIV, 2'd1));
         S_EXC:      word_o = uword(1'b0, C_NONE, S_EXC, '0);
         default:    ;
      endcase
   end

endmodule

// File: rtl/lc3_microsequencer.sv
// LC-3 microsequencer: micro-state register, next-address logic (J/COND/IRD)
// and the control word read straight out of the store for the current state.
module lc3_microsequencer
   import lc3_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        ir,
   input  logic              ben,
   input  logic              psr_15,
   input  logic              acv,
   input  logic              int_req,
   input  logic              mem_r,
   output logic [CTRL_W-1:0] ctrl_sig_40,
   output logic [5:0]        state
);

   logic [5:0]         state_q, state_d;
   logic [UWORD_W-1:0] uinst;
   logic [5:0]         j_mod;

   lc3_ctrl_store u_store (
      .addr_i (state_q),
      .word_o (uinst)
   );

   // The store sets at most one COND per word, so a single OR point suffices
   always_comb begin
      j_mod = uinst[J_HI:J_LO];
      case (uinst[COND_HI:COND_LO])
         C_READY:  j_mod[1] = j_mod[1] | mem_r;
         C_BRANCH: j_mod[2] = j_mod[2] | ben;
         C_ADDR:   j_mod[0] = j_mod[0] | ir[0];
         C_PSR:    j_mod[3] = j_mod[3] | psr_15;
         C_INT:    j_mod[4] = j_mod[4] | int_req;
         C_ACV:    j_mod[5] = j_mod[5] | acv;
         default:  ;
      endcase
      state_d = uinst[IRD_BIT] ? {2'b00, ir[4:1]} : j_mod;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   assign ctrl_sig_40 = uinst[CTRL_HI:CTRL_LO];
   assign state       = state_q;

endmodule
